// File: rtl/pin_entry_checker.sv
// rtl/pin_entry_checker.sv - keypad PIN sequencer with fail counting and timed lockout
//
// Purpose: collects keypad digits, compares a completed entry with a fixed PIN,
// pulses toggle_lock on a match and bad_pin on a mismatch. MAX_FAILS consecutive
// mismatches start a BLOCK_CYCLES lockout during which override is held high.
//
// Ports:
//   clk5        in   system clock (5 Hz)
//   reset       in   asynchronous reset, active-high
//   key_valid   in   one-cycle strobe qualifying key_code
//   key_code    in   0-9 digit, 4'hF clear, anything else ignored
//   toggle_lock out  one-cycle pulse on a correct PIN
//   bad_pin     out  one-cycle pulse on a wrong PIN
//   override    out  high for the whole lockout
//   entry_busy  out  high while a partial entry is held
//   fail_count  out  consecutive wrong entries since last success or lockout
module pin_entry_checker #(
  parameter int unsigned          PIN_LEN        = 4,
  parameter logic [4*PIN_LEN-1:0] PIN            = 16'h1234,
  parameter int unsigned          MAX_FAILS      = 3,
  parameter int unsigned          BLOCK_CYCLES   = 150,
  parameter int unsigned          TIMEOUT_CYCLES = 50
) (
  input  logic                           clk5,
  input  logic                           reset,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  output logic                           toggle_lock,
  output logic                           bad_pin,
  output logic                           override,
  output logic                           entry_busy,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int unsigned BUF_W = 4 * PIN_LEN;
  localparam int unsigned DW    = $clog2(PIN_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW    = $clog2(BLOCK_CYCLES + 1);
  localparam int unsigned FW    = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_RESULT,
    S_BLOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic             toggle_q, toggle_d;
  logic             bad_q, bad_d;
  logic             override_q, override_d;
  logic             busy_q, busy_d;

  logic is_digit;
  logic is_clear;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'hF);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    dcnt_d   = dcnt_q;
    tmo_d    = tmo_q;
    blk_d    = blk_q;
    fail_d   = fail_q;
    toggle_d = 1'b0;
    bad_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          buf_d   = BUF_W'(key_code);
          dcnt_d  = DW'(1);
          tmo_d   = '0;
          state_d = (PIN_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (is_digit) begin
          buf_d  = (buf_q << 4) | BUF_W'(key_code);
          dcnt_d = dcnt_q + DW'(1);
          tmo_d  = '0;
          if (dcnt_q == DW'(PIN_LEN - 1)) begin
            state_d = S_CHECK;
          end
        end else if (is_clear || (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
          // Discard: clear or idle timeout, neither counts as a failure.
          // Ignored codes fall through here, so they do not restart the timer.
          state_d = S_IDLE;
          buf_d   = '0;
          dcnt_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_CHECK: begin
        buf_d  = '0;
        dcnt_d = '0;
        if (buf_q == PIN) begin
          toggle_d = 1'b1;
          fail_d   = '0;
          state_d  = S_RESULT;
        end else begin
          bad_d  = 1'b1;
          fail_d = fail_q + FW'(1);
          if (fail_q == FW'(MAX_FAILS - 1)) begin
            blk_d   = '0;
            state_d = S_BLOCKED;
          end else begin
            state_d = S_RESULT;
          end
        end
      end

      S_RESULT: begin
        state_d = S_IDLE;
      end

      S_BLOCKED: begin
        if (blk_q == BW'(BLOCK_CYCLES - 1)) begin
          blk_d   = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Level outputs are registered copies of the next state.
    override_d = (state_d == S_BLOCKED);
    busy_d     = (state_d == S_ENTRY);
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      dcnt_q     <= '0;
      tmo_q      <= '0;
      blk_q      <= '0;
      fail_q     <= '0;
      toggle_q   <= 1'b0;
      bad_q      <= 1'b0;
      override_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      dcnt_q     <= dcnt_d;
      tmo_q      <= tmo_d;
      blk_q      <= blk_d;
      fail_q     <= fail_d;
      toggle_q   <= toggle_d;
      bad_q      <= bad_d;
      override_q <= override_d;
      busy_q     <= busy_d;
    end
  end

  assign toggle_lock = toggle_q;
  assign bad_pin     = bad_q;
  assign override    = override_q;
  assign entry_busy  = busy_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_pin_entry_checker.sv
// tb/tb_pin_entry_checker.sv - directed and randomized bench for pin_entry_checker
module tb_pin_entry_checker;

  localparam int          PIN_LEN        = 4;
  localparam logic [15:0] PIN            = 16'h1234;
  localparam int          MAX_FAILS      = 3;
  localparam int          BLOCK_CYCLES   = 150;
  localparam int          TIMEOUT_CYCLES = 50;

  logic       clk5 = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       toggle_lock;
  logic       bad_pin;
  logic       override;
  logic       entry_busy;
  logic [1:0] fail_count;

  always #5 clk5 = ~clk5;

  pin_entry_checker #(
    .PIN_LEN       (PIN_LEN),
    .PIN           (PIN),
    .MAX_FAILS     (MAX_FAILS),
    .BLOCK_CYCLES  (BLOCK_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk5       (clk5),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .toggle_lock(toggle_lock),
    .bad_pin    (bad_pin),
    .override   (override),
    .entry_busy (entry_busy),
    .fail_count (fail_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: entry held as a list of digits, lockout as a countdown.
  int m_digits[$];
  int m_idle, m_fails, m_lock_left, m_cool;
  bit m_pending, m_toggle, m_bad;

  function automatic int pin_digit(input int i);
    logic [15:0] p;
    p = PIN;
    return int'((p >> (4 * (PIN_LEN - 1 - i))) & 16'hF);
  endfunction

  task automatic model_clear();
    m_digits.delete();
    m_idle = 0; m_fails = 0; m_lock_left = 0; m_cool = 0;
    m_pending = 0; m_toggle = 0; m_bad = 0;
  endtask

  task automatic model_edge(input bit kv, input logic [3:0] kc);
    m_toggle = 0;
    m_bad = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_pending) begin
      bit ok;
      ok = 1;
      for (int i = 0; i < PIN_LEN; i++) if (m_digits[i] != pin_digit(i)) ok = 0;
      m_digits.delete();
      m_pending = 0;
      if (ok) begin
        m_toggle = 1; m_fails = 0; m_cool = 1;
      end else begin
        m_bad = 1;
        m_fails++;
        if (m_fails == MAX_FAILS) m_lock_left = BLOCK_CYCLES;
        else m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (kv && kc <= 4'd9) begin
      m_digits.push_back(int'(kc));
      m_idle = 0;
      if (m_digits.size() == PIN_LEN) m_pending = 1;
    end else if (m_digits.size() > 0) begin
      if (kv && kc == 4'hF) begin
        m_digits.delete();
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYCLES) begin
          m_digits.delete();
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("toggle_lock", toggle_lock, m_toggle);
    check("bad_pin", bad_pin, m_bad);
    check("override", override, m_lock_left > 0);
    check("entry_busy", entry_busy, (m_digits.size() > 0) && !m_pending);
    check("fail_count", fail_count, m_fails);
  endtask

  task automatic step(input bit kv, input logic [3:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk5);
    model_edge(kv, kc);
    @(negedge clk5);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  task automatic send_seq(input logic [31:0] seq, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq[4*(n-1-i) +: 4]);
      idle(gap);
    end
  endtask

  task automatic async_reset(input int off);
    @(negedge clk5);
    #off;
    reset = 1'b1;
    key_valid = 1'b0;
    #1;
    check("rst_toggle", toggle_lock, 0);
    check("rst_bad", bad_pin, 0);
    check("rst_override", override, 0);
    check("rst_busy", entry_busy, 0);
    check("rst_fails", fail_count, 0);
    model_clear();
    @(posedge clk5);
    @(negedge clk5);
    reset = 1'b0;
  endtask

  int ovr_len, tog_in_lock;

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    model_clear();
    repeat (2) @(negedge clk5);
    check("reset_state_toggle", toggle_lock, 0);
    check("reset_state_override", override, 0);
    check("reset_state_fails", fail_count, 0);
    reset = 1'b0;

    // Correct PIN, then two wrong entries followed by the correct one.
    send_seq(32'h1234, 4, 0); idle(3);
    send_seq(32'h1235, 4, 0); idle(3);
    send_seq(32'h1235, 4, 1); idle(3);
    send_seq(32'h1234, 4, 0); idle(3);

    // Clear mid-entry, then a partial entry, clear, and the correct PIN.
    send_seq(32'h12, 2, 0); step(1'b1, 4'hF);
    send_seq(32'h34, 2, 0); step(1'b1, 4'hF); idle(2);
    send_seq(32'h1234, 4, 0); idle(3);

    // Partial entry abandoned by timeout; ignored codes in between.
    send_seq(32'h12, 2, 0); step(1'b1, 4'hB); idle(TIMEOUT_CYCLES + 2);
    send_seq(32'h5, 1, 0); idle(TIMEOUT_CYCLES - 1); send_seq(32'h6, 1, 0);
    step(1'b1, 4'hF); idle(2);

    // Three wrong entries: lockout length and no toggle while locked out.
    send_seq(32'h1111, 4, 0); idle(3);
    send_seq(32'h2222, 4, 0); idle(3);
    send_seq(32'h9999, 4, 0);
    ovr_len = 0;
    tog_in_lock = 0;
    for (int i = 0; i < 200; i++) begin
      if ((i % 20) >= 10 && (i % 20) < 14 && i < 140) step(1'b1, 4'((i % 10) + 1));
      else step(1'b0, 4'h0);
      if (override) ovr_len++;
      if (toggle_lock) tog_in_lock++;
    end
    check("lockout_len", ovr_len, BLOCK_CYCLES);
    check("lockout_toggle", tog_in_lock, 0);
    send_seq(32'h1234, 4, 0); idle(3);

    // Reset mid-lockout and mid-entry.
    send_seq(32'h1111, 4, 0); idle(3);
    send_seq(32'h1111, 4, 0); idle(3);
    send_seq(32'h1111, 4, 0); idle(20);
    async_reset(2);
    idle(2);
    send_seq(32'h1234, 4, 0); idle(3);
    send_seq(32'h12, 2, 0);
    async_reset(3);
    idle(2);
    send_seq(32'h1234, 4, 0); idle(3);

    // Randomized entries.
    for (int it = 0; it < 90; it++) begin
      int r;
      logic [31:0] s;
      r = int'($urandom_range(0, 9));
      s = '0;
      if (it == 45) async_reset(int'($urandom_range(1, 3)));
      if (r < 4) begin
        send_seq({16'h0, PIN}, 4, int'($urandom_range(0, 2)));
      end else if (r < 7) begin
        for (int j = 0; j < 4; j++) s[4*j +: 4] = 4'($urandom_range(0, 9));
        send_seq(s, 4, int'($urandom_range(0, 2)));
      end else if (r == 7) begin
        send_seq(32'h12, 2, 0);
        step(1'b1, 4'($urandom_range(10, 14)));
        send_seq(32'h34, 2, 0);
      end else if (r == 8) begin
        send_seq(32'h12, 2, 0);
        step(1'b1, 4'hF);
      end else begin
        s[3:0] = 4'($urandom_range(0, 9));
        send_seq(s, 1, 0);
        idle(int'($urandom_range(45, 55)));
      end
      idle(int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
